// File: rtl/mult_div_unit_if.sv
// Operand/result bundle for mult_div_unit: request side from the issuing pipeline,
// HI/LO results and status back from the unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             div_by_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  hi_o, lo_o, busy_o, done_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output hi_o, lo_o, busy_o, done_o, div_by_zero_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Signed MULT/DIV are built only when MULT_DIV_SIGNED_EN is defined; otherwise op_i[0] is ignored.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;   // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_q;
    logic               is_div_q, b_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, dbz_q;

    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULT_DIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, rem_neg_q;
    assign a_neg = bus.op_i[0] & bus.a_i[WIDTH-1];
    assign b_neg = bus.op_i[0] & bus.b_i[WIDTH-1];
    assign a_mag = a_neg ? -bus.a_i : bus.a_i;
    assign b_mag = b_neg ? -bus.b_i : bus.b_i;
`else
    logic unused_op0;
    assign unused_op0 = bus.op_i[0];
    assign a_mag = bus.a_i;
    assign b_mag = bus.b_i;
`endif

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (!is_div_q) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (div_ge) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    always_comb begin
        prod = acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULT_DIV_SIGNED_EN
        if (neg_q) begin
            prod = -acc_q;
            quo  = -acc_q[WIDTH-1:0];
        end
        if (rem_neg_q) begin
            rem = -acc_q[2*WIDTH-1:WIDTH];
        end
`endif
        if (!is_div_q) begin
            {fix_hi, fix_lo} = prod;
        end else if (b_zero_q) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        state_q  <= StRun;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                        is_div_q <= bus.op_i[1];
                        a_q      <= bus.a_i;
                        b_zero_q <= (bus.b_i == '0);
                        opb_q    <= bus.op_i[1] ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, (bus.op_i[1] ? a_mag : b_mag)};
`ifdef MULT_DIV_SIGNED_EN
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
`endif
                    end
                end
                StRun: begin
                    // The extra edge at cnt_q == WIDTH places the FIX edge at accept + WIDTH + 2.
                    if (cnt_q == CntW'(WIDTH)) begin
                        state_q <= StFix;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dbz_q   <= is_div_q & b_zero_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.hi_o          = hi_q;
    assign bus.lo_o          = lo_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.div_by_zero_o = dbz_q;
endmodule
